// File: rtl/nrzi_tx_ctrl.sv
// ---------------------------------------------------------------------------
// nrzi_tx_ctrl
// Transmit-side controller for the nrzi encoder. It accepts a parallel word
// over a valid/ready handshake and pulses the encoder reset for one cycle.
// It then shifts the word out MSB-first on enc_x, inserting a 0 stuff bit
// after STUFF_RUN consecutive data 1s when STUFF_EN is set.
//
// Ports
//   clock       in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   data_in     in   [WIDTH-1:0] word, sampled on the accept edge
//   data_valid  in   producer has a word
//   data_ready  out  controller can accept (IDLE and not in reset)
//   enc_reset   out  drives nrzi reset (reset or CLEAR state)
//   enc_x       out  drives nrzi x
//   bit_valid   out  enc_x carries a frame bit this cycle
//   stuffed     out  current bit is a stuff bit
//   busy        out  frame in progress
//   done        out  one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
module nrzi_tx_ctrl #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned STUFF_EN  = 1,
    parameter int unsigned STUFF_RUN = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             enc_reset,
    output logic             enc_x,
    output logic             bit_valid,
    output logic             stuffed,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned RW = $clog2(STUFF_RUN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_STUFF,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bitcnt;
    logic [RW-1:0]    r_run;
    logic             r_enc_x;
    logic             r_bit_valid;
    logic             r_stuffed;
    logic             r_busy;
    logic             r_done;

    logic w_bit;
    logic w_stuff;
    logic w_last;
    logic w_accept;

    // Current data bit, and whether it completes a run of ones
    assign w_bit    = r_shreg[WIDTH-1];
    assign w_stuff  = (STUFF_EN != 0) && w_bit && (r_run == RW'(STUFF_RUN - 1));
    assign w_last   = (r_bitcnt == CW'(WIDTH - 1));
    assign w_accept = data_valid & data_ready;

    // Encoder reset must follow the controller reset with no register delay
    assign enc_reset  = reset | (r_state == S_CLEAR);
    assign data_ready = (r_state == S_IDLE) & ~reset;

    assign enc_x     = r_enc_x;
    assign bit_valid = r_bit_valid;
    assign stuffed   = r_stuffed;
    assign busy      = r_busy;
    assign done      = r_done;

    // Frame sequencer; outputs are registered for the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_run       <= '0;
            r_enc_x     <= 1'b0;
            r_bit_valid <= 1'b0;
            r_stuffed   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg  <= data_in;
                        r_bitcnt <= '0;
                        r_run    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    r_enc_x     <= r_shreg[WIDTH-1];
                    r_bit_valid <= 1'b1;
                    r_state     <= S_SHIFT;
                end

                S_SHIFT: begin
                    r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt + CW'(1);
                    r_run    <= w_bit ? (r_run + RW'(1)) : '0;
                    if (w_stuff) begin
                        // Stuff takes priority even on the final data bit
                        r_enc_x     <= 1'b0;
                        r_stuffed   <= 1'b1;
                        r_state     <= S_STUFF;
                    end else if (w_last) begin
                        r_enc_x     <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_enc_x     <= r_shreg[WIDTH-2];
                    end
                end

                S_STUFF: begin
                    r_run     <= '0;
                    r_stuffed <= 1'b0;
                    if (r_bitcnt == CW'(WIDTH)) begin
                        r_enc_x     <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        // shreg was already advanced by the bit that triggered the stuff
                        r_enc_x <= r_shreg[WIDTH-1];
                        r_state <= S_SHIFT;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_enc_x     <= 1'b0;
                    r_bit_valid <= 1'b0;
                    r_stuffed   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrzi_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nrzi_tx_ctrl
// Directed bench for nrzi_tx_ctrl. A behavioural frame model pushes the
// expected per-cycle output vector when a word is offered; each cycle the
// observed vector is popped and compared.
// Vector order: {enc_reset, data_ready, enc_x, bit_valid, stuffed, busy, done}
// ---------------------------------------------------------------------------
module tb_nrzi_tx_ctrl;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned STUFF_RUN = 6;

    typedef struct {
        logic [6:0] v;
        string      tag;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             dv;
    logic             sel;     // 0: stuffing DUT, 1: no-stuff DUT

    logic rdy_a, er_a, x_a, bv_a, st_a, bz_a, dn_a;
    logic rdy_b, er_b, x_b, bv_b, st_b, bz_b, dn_b;
    logic [6:0] obs;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    nrzi_tx_ctrl #(.WIDTH(WIDTH), .STUFF_EN(1), .STUFF_RUN(STUFF_RUN)) dut (
        .clock(clk), .reset(rst), .data_in(din), .data_valid(dv & ~sel),
        .data_ready(rdy_a), .enc_reset(er_a), .enc_x(x_a), .bit_valid(bv_a),
        .stuffed(st_a), .busy(bz_a), .done(dn_a)
    );

    nrzi_tx_ctrl #(.WIDTH(WIDTH), .STUFF_EN(0), .STUFF_RUN(STUFF_RUN)) dut_ns (
        .clock(clk), .reset(rst), .data_in(din), .data_valid(dv & sel),
        .data_ready(rdy_b), .enc_reset(er_b), .enc_x(x_b), .bit_valid(bv_b),
        .stuffed(st_b), .busy(bz_b), .done(dn_b)
    );

    always_comb begin
        obs = sel ? {er_b, rdy_b, x_b, bv_b, st_b, bz_b, dn_b}
                  : {er_a, rdy_a, x_a, bv_a, st_a, bz_a, dn_a};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void push_exp(logic [6:0] v, string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endfunction

    // Frame model: counts ones and emits a stuff 0 once the run reaches STUFF_RUN
    function automatic void push_frame(logic [WIDTH-1:0] w, bit sen, string name);
        int run;
        int c;
        run = 0;
        c   = 1;
        push_exp(7'b1000010, $sformatf("%s c%0d clear", name, c));
        for (int i = WIDTH - 1; i >= 0; i--) begin
            c++;
            push_exp({2'b00, w[i], 4'b1010}, $sformatf("%s c%0d bit%0d", name, c, i));
            run = w[i] ? run + 1 : 0;
            if (sen && run == STUFF_RUN) begin
                c++;
                push_exp(7'b0001110, $sformatf("%s c%0d stuff", name, c));
                run = 0;
            end
        end
        c++;
        push_exp(7'b0000011, $sformatf("%s c%0d done", name, c));
        c++;
        push_exp(7'b0100000, $sformatf("%s c%0d idle", name, c));
    endfunction

    task automatic check_now();
        exp_t e;
        #1;
        e = exp_q.pop_front();
        n_tests++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s obs=%b exp=%b", e.tag, obs, e.v);
        end
    endtask

    task automatic tick_check();
        @(posedge clk);
        #1;
        check_now();
    endtask

    // Offer one word from a checked IDLE cycle and follow it to the next IDLE
    task automatic send(logic [WIDTH-1:0] w, bit sen, string name);
        din = w;
        dv  = 1'b1;
        push_frame(w, sen, name);
        @(posedge clk);
        #1;
        dv  = 1'b0;
        din = '0;
        check_now();
        while (exp_q.size() > 0) tick_check();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        din = '0;
        dv  = 1'b0;
        sel = 1'b0;

        // Reset values, with enc_reset following reset
        @(posedge clk);
        push_exp(7'b1000000, "reset");
        tick_check();
        rst = 1'b0;
        push_exp(7'b0100000, "idle after reset");
        tick_check();

        send(16'hF161, 1'b1, "f161");
        send(16'hFFFF, 1'b1, "ffff");
        send(16'h003F, 1'b1, "003f");

        // Back-to-back with data_valid held high across both frames
        din = 16'hCF0C;
        dv  = 1'b1;
        push_frame(16'hCF0C, 1'b1, "cf0c");
        push_frame(16'h8C00, 1'b1, "8c00b2b");
        @(posedge clk);
        #1;
        din = 16'h8C00;
        check_now();
        while (exp_q.size() > 0) tick_check();
        dv  = 1'b0;
        din = '0;

        // Stuffing disabled
        sel = 1'b1;
        #1;
        push_exp(7'b0100000, "ns idle");
        check_now();
        send(16'hFFFF, 1'b0, "ns_ffff");
        sel = 1'b0;

        // Reset in cycle 9 of a 0xFFFF frame (first one after the first stuff)
        din = 16'hFFFF;
        dv  = 1'b1;
        push_frame(16'hFFFF, 1'b1, "abort");
        @(posedge clk);
        #1;
        dv  = 1'b0;
        check_now();
        for (int k = 2; k <= 8; k++) tick_check();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp(7'b1011010, "abort c9 reset");
        check_now();
        push_exp(7'b1000000, "abort c10 idle in reset");
        tick_check();
        rst = 1'b0;
        push_exp(7'b0100000, "abort c11 idle");
        tick_check();
        send(16'h8C00, 1'b1, "8c00_after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nrzi_tx_ctrl.md
# nrzi_tx_ctrl

Transmit-side controller for the `nrzi` encoder. It accepts parallel words over a valid/ready handshake and clears the encoder before each frame. It then feeds the word MSB-first into the encoder's `x` input, one bit per clock, inserting a 0 stuff bit after a configurable run of consecutive 1s. It sits directly in front of `nrzi`, driving that block's `reset` and `x` pins, and signals frame completion to the upstream producer.

## Interface
- `WIDTH`, 16: data bits per frame; ≥ 2.
- `STUFF_EN`, 1: 1 enables bit stuffing; 0 disables it.
- `STUFF_RUN`, 6: number of consecutive data 1s that triggers a stuff bit; range 1..WIDTH.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  word to transmit; sampled on the accept edge.
- `data_valid`  in  1  producer has a word.
- `data_ready`  out  1  controller can accept; a word is accepted on an edge with `data_valid & data_ready`.
- `enc_reset`  out  1  drives `nrzi` reset.
- `enc_x`  out  1  drives `nrzi` x.
- `bit_valid`  out  1  `enc_x` carries a frame bit (data or stuff) this cycle.
- `stuffed`  out  1  the current bit is a stuff bit.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse at end of frame.

## Operation
- States: IDLE, CLEAR, SHIFT, STUFF, DONE.
- Registers:
  - `shreg[WIDTH]`: shift register.
  - `bitcnt`: $clog2(WIDTH+1) bits, counts data bits sent.
  - `run`: $clog2(STUFF_RUN+1) bits, current run of 1s.
- IDLE:
  - `data_ready=1`.
  - On accept: `shreg<=data_in`, `bitcnt<=0`, `run<=0`, go to CLEAR.
- CLEAR:
  - `enc_reset=1`, `enc_x=0`, `bit_valid=0`. Lasts exactly one cycle; go to SHIFT.
- SHIFT:
  - Outputs: `enc_x=shreg[WIDTH-1]`, `bit_valid=1`.
  - Each edge: shift `shreg` left with 0 fill, `bitcnt++`.
  - If the bit is 1: `run++`. If it is 0: `run<=0`.
  - Stuff condition: `STUFF_EN=1`, bit is 1, and `run==STUFF_RUN-1` (this bit completes the run).
  - Next state:
    - STUFF if the stuff condition holds, including on the last data bit.
    - Else DONE if `bitcnt==WIDTH-1`.
    - Else stay in SHIFT.
- STUFF:
  - Outputs: `enc_x=0`, `bit_valid=1`, `stuffed=1`. Sets `run<=0`; `bitcnt` is unchanged.
  - Next: DONE if `bitcnt==WIDTH`, else SHIFT.
- DONE:
  - `done=1`, `enc_x=0`, `bit_valid=0`; go to IDLE.
- `busy` is high in every state except IDLE.
- `data_valid` is ignored outside IDLE. `data_in` need not be held after the accept edge.
- `run` never carries across frames.

## Timing
- Reset:
  - `enc_reset = reset | (state==CLEAR)`, combinational, so the encoder is held in reset whenever the controller is.
  - `data_ready = (state==IDLE) & ~reset`.
  - After the reset edge: state IDLE; `enc_x=0`, `bit_valid=0`, `stuffed=0`, `busy=0`, `done=0`; `shreg`, `bitcnt`, `run` are 0.
- Reset mid-frame: the frame is aborted with no `done`. The controller returns to IDLE on the next edge, and `enc_reset` is high for the whole reset cycle.
- Cycle numbering: accept edge = edge 0.
  - Cycle 1: CLEAR.
  - Cycles 2..N+1: the N frame bits, with N = WIDTH + number of stuffs.
  - Cycle N+2: DONE.
  - Cycle N+3: IDLE, `data_ready=1`.
- Throughput: back-to-back words with `data_valid` held high are accepted every N+3 cycles.
- Outputs other than `enc_reset` and `data_ready` are decoded from registered state only; there are no combinational input-to-output paths.
- The encoder sees its first data bit the cycle after its reset deasserts.

## Test plan
- **Word 0xF161, WIDTH=16, stuffing on:**
  - `enc_x` over cycles 2..17 is 1111000101100001.
  - `stuffed` never asserts.
  - `done` is high in cycle 18; `data_ready` returns in cycle 19.
  - Encoder `z` matches the NRZI golden model.
- **Word 0xFFFF:**
  - Bit stream is 111111 0 111111 0 1111 over cycles 2..19.
  - `stuffed` is high in cycles 8 and 15.
  - `done` is high in cycle 20.
- **Word 0x003F (stuff on final bit):**
  - 17 bit cycles, with `stuffed` high in cycle 18.
  - `done` is high in cycle 19.
- **Back-to-back 0xCF0C then 0x8C00, `data_valid` held high:**
  - Second accept on the edge ending cycle 19.
  - `enc_reset` pulses one cycle before each frame.
  - No stuffs in either frame.
- **Word 0xFFFF with `STUFF_EN=0`:**
  - 16 ones, `stuffed` stays 0, `done` is high in cycle 18.
- **Reset asserted in cycle 9 of a 0xFFFF frame:**
  - `enc_reset=1` that cycle.
  - State is IDLE with all outputs at reset values after the edge; `done` never pulses.
  - A following 0x8C00 transmits correctly with `run` starting at 0.
